fifo_burst_writer: RTL
======================

Name: fifo_burst_writer

Overview:
Producer-side burst engine that sits directly upstream of async_fifo in the PROD_CLK domain. On a START request it writes BURST_LEN words into the FIFO write port. Each word follows a deterministic pattern, and the engine honours FULL back-pressure and a programmable idle gap between writes. It replaces the bench-only producer with synthesizable RTL and reports a write count and a running checksum for end-to-end data checking at the consumer.

Parameters:
DATA_WIDTH, 8, width of FIFO data word
MAX_BURST, 1024, maximum words per burst
CNT_WIDTH, $clog2(MAX_BURST+1) (11), width of length/count fields
IDLE_WIDTH, 4, width of the WR_IDLE gap field

Ports:
PROD_CLK  in  1  producer clock; only clock in the block
RST  in  1  reset, synchronous, active-high
START  in  1  burst request; accepted only in IDLE
ABORT  in  1  synchronous abort of the burst in progress
BURST_LEN  in  CNT_WIDTH  words in burst, sampled on accepted START
WR_IDLE  in  IDLE_WIDTH  idle cycles after each non-final write, sampled on START
SEED  in  DATA_WIDTH  pattern step, sampled on START
I_FULL  in  1  FIFO full flag, already in PROD_CLK domain
O_WR_EN  out  1  FIFO write enable
O_DATA  out  DATA_WIDTH  FIFO write data
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse at burst end, including on abort
WR_COUNT  out  CNT_WIDTH  committed writes in current/last burst
CHECKSUM  out  DATA_WIDTH  sum mod 2^DATA_WIDTH of committed words

Behaviour:
- Reset: one clock and one reset only. RST is synchronous and active-high; it overrides all other inputs on the same edge.
- Reset values:
  - State = IDLE.
  - O_WR_EN = 0, O_DATA = 0, BUSY = 0, DONE = 0.
  - WR_COUNT = 0, CHECKSUM = 0.
- State machine states: IDLE, WRITE, GAP, FINISH.
- IDLE:
  - START=1 at edge k is accepted. On that edge: latch BURST_LEN, WR_IDLE and SEED; clear WR_COUNT and CHECKSUM; load data register with 1.
  - Next state: WRITE, or FINISH if BURST_LEN == 0.
  - BURST_LEN > MAX_BURST is clamped to MAX_BURST.
- WRITE:
  - O_WR_EN = !I_FULL, combinational. O_DATA = data register, registered.
  - A write commits at an edge where O_WR_EN = 1. On commit:
    - WR_COUNT += 1.
    - CHECKSUM += O_DATA, mod 2^DATA_WIDTH.
    - Data register += latched SEED, mod 2^DATA_WIDTH. Word i is therefore (SEED*i + 1) mod 2^DATA_WIDTH; no multiplier.
  - I_FULL = 1: stay in WRITE, no commit, O_DATA held stable.
  - After the last commit: go to FINISH. No gap after the final word.
  - After any other commit: go to GAP if WR_IDLE > 0, else stay in WRITE. Back-to-back commits happen every cycle.
- GAP: O_WR_EN = 0 for exactly latched WR_IDLE cycles, then WRITE.
- FINISH: DONE = 1 for one cycle, BUSY = 1, then IDLE.
- Latency:
  - START accepted at edge 0 → first possible O_WR_EN in cycle 1.
  - Last commit at end of cycle N → DONE in cycle N+1.
- Status outputs: WR_COUNT and CHECKSUM are registered, visible the cycle after a commit. They are final by the DONE cycle and held until the next accepted START.
- START while BUSY is ignored; no queuing.
- ABORT = 1 in WRITE or GAP:
  - Any commit on that edge is suppressed.
  - O_WR_EN is forced 0 that cycle.
  - Next state: FINISH. DONE pulses; WR_COUNT reflects commits so far.
- ABORT in IDLE or FINISH has no effect.
- RST mid-burst: returns to IDLE with reset values next cycle; no DONE pulse.
- O_WR_EN is never 1 while I_FULL = 1.

Test Plan:
- Basic burst: SEED=0x01, BURST_LEN=4, WR_IDLE=0, I_FULL=0, START at edge 0 → O_WR_EN high cycles 1-4, O_DATA 01,02,03,04; DONE cycle 5; WR_COUNT=4, CHECKSUM=0x0A.
- Idle gap: same as basic burst with WR_IDLE=2 → commits cycles 1,4,7,10; DONE cycle 11; O_WR_EN low in all gap cycles.
- Back-pressure:
  - Setup: SEED=0x01, BURST_LEN=3, I_FULL=1 in cycles 2-4.
  - Commits: cycles 1,5,6, with data 01,02,03.
  - O_WR_EN = 0 in cycles 2-4, with O_DATA held at 02.
  - DONE cycle 7.
- Wrap and zero length:
  - SEED=0x80, BURST_LEN=3 → data 01,81,01, CHECKSUM=0x83.
  - BURST_LEN=0 → DONE cycle 1, no O_WR_EN, WR_COUNT=0.
- Abort/ignore: BURST_LEN=10, WR_IDLE=0, ABORT at cycle 4 → commits cycles 1-3 only; DONE cycle 5; WR_COUNT=3. A START at cycle 2 has no effect.
- Reset mid-burst: RST at cycle 3 of a BURST_LEN=8 burst → cycle 4 all outputs 0, IDLE, no DONE. A new START at cycle 5 begins with data 01.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// Producer burst engine: writes BURST_LEN patterned words (SEED*i+1) into a FIFO, first write the cycle after START.
// Stalls with data held while I_FULL is high; DONE pulses the cycle after the last commit or after an abort.
module fifo_burst_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 1024,
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1),
  parameter int IDLE_WIDTH = 4
) (
  input  logic                  PROD_CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CNT_WIDTH-1:0]  BURST_LEN,
  input  logic [IDLE_WIDTH-1:0] WR_IDLE,
  input  logic [DATA_WIDTH-1:0] SEED,
  input  logic                  I_FULL,
  output logic                  O_WR_EN,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_WIDTH-1:0]  WR_COUNT,
  output logic [DATA_WIDTH-1:0] CHECKSUM
);

  localparam logic [CNT_WIDTH-1:0]  MAX_LEN  = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [IDLE_WIDTH-1:0] IDLE_ONE = IDLE_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_FINISH} state_t;

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  wr_count_q;
  logic [IDLE_WIDTH-1:0] idle_q;
  logic [IDLE_WIDTH-1:0] gap_cnt_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CNT_WIDTH-1:0]  start_len;
  logic                  wr_en;
  logic                  last_word;

  assign start_len = (BURST_LEN > MAX_LEN) ? MAX_LEN : BURST_LEN;
  // Abort masks the write in the same cycle so no word is committed on the abort edge.
  assign wr_en     = (state_q == S_WRITE) && !I_FULL && !ABORT;
  assign last_word = (wr_count_q + CNT_ONE) == len_q;

  always_ff @(posedge PROD_CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_count_q <= '0;
      idle_q     <= '0;
      gap_cnt_q  <= '0;
      seed_q     <= '0;
      data_q     <= '0;
      checksum_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            len_q      <= start_len;
            idle_q     <= WR_IDLE;
            seed_q     <= SEED;
            wr_count_q <= '0;
            checksum_q <= '0;
            data_q     <= DATA_ONE;
            busy_q     <= 1'b1;
            if (start_len == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (ABORT) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else if (wr_en) begin
            wr_count_q <= wr_count_q + CNT_ONE;
            checksum_q <= checksum_q + data_q;
            data_q     <= data_q + seed_q;
            if (last_word) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else if (idle_q != '0) begin
              state_q   <= S_GAP;
              gap_cnt_q <= idle_q;
            end
          end
        end
        S_GAP: begin
          if (ABORT) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else if (gap_cnt_q <= IDLE_ONE) begin
            state_q <= S_WRITE;
          end else begin
            gap_cnt_q <= gap_cnt_q - IDLE_ONE;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign O_WR_EN  = wr_en;
  assign O_DATA   = data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign WR_COUNT = wr_count_q;
  assign CHECKSUM = checksum_q;

endmodule
